// File: rtl/accum_arbiter_if.sv
// rtl/accum_arbiter_if.sv - request/operand/ack and accumulator status bundle for accum_arbiter
interface accum_arbiter_if #(
    parameter int WIDTH = 7
);
    logic             clr;
    logic             req_a;
    logic [WIDTH-1:0] op_a;
    logic             sub_a;
    logic             req_b;
    logic [WIDTH-1:0] op_b;
    logic             sub_b;
    logic             ack_a;
    logic             ack_b;
    logic             busy;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             last_grant;

    modport master (
        output clr, req_a, op_a, sub_a, req_b, op_b, sub_b,
        input  ack_a, ack_b, busy, acc, carry, last_grant
    );

    modport slave (
        input  clr, req_a, op_a, sub_a, req_b, op_b, sub_b,
        output ack_a, ack_b, busy, acc, carry, last_grant
    );
endinterface

// File: rtl/accum_arbiter.sv
// rtl/accum_arbiter.sv - round-robin arbiter sharing one add/sub accumulator between two requesters
module accum_arbiter #(
    parameter int WIDTH    = 7,
    parameter int SATURATE = 0
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    accum_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, EXEC, ACK} state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH:0]   result;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            op_q         <= '0;
            sub_q        <= 1'b0;
            acc_q        <= '0;
            carry_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            sub_q        <= sub_d;
            acc_q        <= acc_d;
            carry_q      <= carry_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        op_d         = op_q;
        sub_d        = sub_q;
        acc_d        = acc_q;
        carry_d      = carry_q;
        last_grant_d = last_grant_q;
        // Top bit is carry-out for add and borrow for subtract.
        result = sub_q ? ({1'b0, acc_q} - {1'b0, op_q})
                       : ({1'b0, acc_q} + {1'b0, op_q});

        case (state_q)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_grant_q)) begin
                    grant_d = 1'b0;
                    state_d = LOAD;
                end else if (bus.req_b) begin
                    grant_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                op_d    = grant_q ? bus.op_b  : bus.op_a;
                sub_d   = grant_q ? bus.sub_b : bus.sub_a;
                state_d = EXEC;
            end
            EXEC: begin
                if ((SATURATE != 0) && result[WIDTH]) begin
                    acc_d = sub_q ? '0 : {WIDTH{1'b1}};
                end else begin
                    acc_d = result[WIDTH-1:0];
                end
                carry_d = carry_q | result[WIDTH];
                state_d = ACK;
            end
            ACK: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Clear overrides any EXEC commit in the same cycle.
        if (bus.clr) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end
    end

    assign bus.ack_a      = (state_q == ACK) && !grant_q;
    assign bus.ack_b      = (state_q == ACK) && grant_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.acc        = acc_q;
    assign bus.carry      = carry_q;
    assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_accum_arbiter.sv
// tb/tb_accum_arbiter.sv - randomized bench for accum_arbiter, wrap and saturate variants side by side
module tb_accum_arbiter;
    localparam int W    = 7;
    localparam int MOD  = 1 << W;
    localparam int MAXV = MOD - 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic         clr, req_a, sub_a, req_b, sub_b;
    logic [W-1:0] op_a, op_b;

    accum_arbiter_if #(.WIDTH(W)) bus0 ();
    accum_arbiter_if #(.WIDTH(W)) bus1 ();

    assign bus0.clr = clr;   assign bus1.clr = clr;
    assign bus0.req_a = req_a; assign bus1.req_a = req_a;
    assign bus0.op_a = op_a;   assign bus1.op_a = op_a;
    assign bus0.sub_a = sub_a; assign bus1.sub_a = sub_a;
    assign bus0.req_b = req_b; assign bus1.req_b = req_b;
    assign bus0.op_b = op_b;   assign bus1.op_b = op_b;
    assign bus0.sub_b = sub_b; assign bus1.sub_b = sub_b;

    accum_arbiter #(.WIDTH(W), .SATURATE(0)) dut0 (.CLOCK_50(clk), .resetn(resetn), .bus(bus0.slave));
    accum_arbiter #(.WIDTH(W), .SATURATE(1)) dut1 (.CLOCK_50(clk), .resetn(resetn), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;
    int m_acc [2];
    bit m_carry [2];
    bit m_lg;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_reset();
        m_acc[0] = 0; m_acc[1] = 0;
        m_carry[0] = 0; m_carry[1] = 0;
        m_lg = 1'b1;
    endfunction

    // Index s: 0 = wrapping instance, 1 = saturating instance.
    function automatic void model_apply(int op, bit sub, bit cleared);
        for (int s = 0; s < 2; s++) begin
            int r;
            bit c;
            if (cleared) begin
                m_acc[s] = 0;
                m_carry[s] = 1'b0;
            end else begin
                if (sub) begin
                    c = (op > m_acc[s]);
                    r = c ? ((s == 1) ? 0 : m_acc[s] - op + MOD) : m_acc[s] - op;
                end else begin
                    r = m_acc[s] + op;
                    c = (r > MAXV);
                    if (c) r = (s == 1) ? MAXV : r - MOD;
                end
                m_acc[s] = r;
                m_carry[s] = m_carry[s] | c;
            end
        end
    endfunction

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_apply(0, 1'b0, 1'b1);
    endtask

    // Called in the IDLE cycle where the request is first seen; returns in the IDLE cycle after ACK.
    task automatic wait_ack(input bit who, input int op, input bit sub, input bit clr_exec, input string tag);
        int seen = 0;
        for (int i = 1; i <= 6 && seen == 0; i++) begin
            step();
            clr = 1'b0;
            if (i == 2) begin
                if (who) begin op_b = W'($urandom); sub_b = ~sub_b; end
                else     begin op_a = W'($urandom); sub_a = ~sub_a; end
                if (clr_exec) clr = 1'b1;
            end
            if (bus0.ack_a | bus0.ack_b | bus1.ack_a | bus1.ack_b) begin
                seen = i;
                model_apply(op, sub, clr_exec);
                checks++;
                if (i != 3) begin
                    errors++;
                    $display("FAIL %s latency: ack after %0d cycles, want 3", tag, i);
                end
                checks++;
                if ({bus0.ack_b, bus0.ack_a, bus1.ack_b, bus1.ack_a} !== (who ? 4'b1010 : 4'b0101)) begin
                    errors++;
                    $display("FAIL %s ack_select: got %b want %b", tag,
                             {bus0.ack_b, bus0.ack_a, bus1.ack_b, bus1.ack_a}, (who ? 4'b1010 : 4'b0101));
                end
                checks++;
                if (bus0.acc !== W'(m_acc[0]) || bus0.carry !== m_carry[0]) begin
                    errors++;
                    $display("FAIL %s wrap_result: acc=%0d carry=%b want acc=%0d carry=%b",
                             tag, bus0.acc, bus0.carry, m_acc[0], m_carry[0]);
                end
                checks++;
                if (bus1.acc !== W'(m_acc[1]) || bus1.carry !== m_carry[1]) begin
                    errors++;
                    $display("FAIL %s sat_result: acc=%0d carry=%b want acc=%0d carry=%b",
                             tag, bus1.acc, bus1.carry, m_acc[1], m_carry[1]);
                end
                checks++;
                if (bus0.busy !== 1'b1 || bus1.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_in_ack: got %b%b want 11", tag, bus0.busy, bus1.busy);
                end
                if (who) req_b = 1'b0; else req_a = 1'b0;
            end
        end
        if (seen == 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no ack within 6 cycles, want ack at 3", tag);
        end
        m_lg = who;
        step();
        checks++;
        if ({bus0.ack_a, bus0.ack_b, bus1.ack_a, bus1.ack_b, bus0.busy, bus1.busy} !== 6'b0
            || bus0.last_grant !== m_lg || bus1.last_grant !== m_lg) begin
            errors++;
            $display("FAIL %s after_ack: acks=%b busy=%b%b last_grant=%b%b want acks=0000 busy=00 last_grant=%b",
                     tag, {bus0.ack_a, bus0.ack_b, bus1.ack_a, bus1.ack_b}, bus0.busy, bus1.busy,
                     bus0.last_grant, bus1.last_grant, m_lg);
        end
    endtask

    task automatic do_req(input bit ra, input bit rb, input int oa, input int ob,
                          input bit sa, input bit sb, input bit clr_exec, input string tag);
        bit first;
        op_a = W'(oa); sub_a = sa; op_b = W'(ob); sub_b = sb;
        req_a = ra; req_b = rb;
        first = (ra && rb) ? ~m_lg : rb;
        if (first) wait_ack(1'b1, ob, sb, clr_exec, tag);
        else       wait_ack(1'b0, oa, sa, clr_exec, tag);
        if (ra && rb) begin
            if (first) wait_ack(1'b0, oa, sa, 1'b0, tag);
            else       wait_ack(1'b1, ob, sb, 1'b0, tag);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clr = 0; req_a = 0; req_b = 0; sub_a = 0; sub_b = 0; op_a = '0; op_b = '0;
        step(); step();
        model_reset();
        checks++;
        if (bus0.acc !== '0 || bus1.acc !== '0 || bus0.carry !== 1'b0 || bus1.carry !== 1'b0
            || {bus0.ack_a, bus0.ack_b, bus1.ack_a, bus1.ack_b} !== 4'b0
            || bus0.busy !== 1'b0 || bus1.busy !== 1'b0
            || bus0.last_grant !== 1'b1 || bus1.last_grant !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: acc=%0d/%0d carry=%b%b busy=%b%b last_grant=%b%b want 0/0 00 00 11",
                     bus0.acc, bus1.acc, bus0.carry, bus1.carry, bus0.busy, bus1.busy,
                     bus0.last_grant, bus1.last_grant);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        do_req(1, 0, 5, 0, 0, 0, 0, "basic");
        checks++;
        if (bus0.acc !== 7'd5 || bus0.carry !== 1'b0 || bus0.last_grant !== 1'b0) begin
            errors++;
            $display("FAIL basic_const: acc=%0d carry=%b last_grant=%b want 5 0 0", bus0.acc, bus0.carry, bus0.last_grant);
        end
    endtask

    task automatic test_overflow();
        pulse_clr();
        do_req(1, 0, 120, 0, 0, 0, 0, "ovf_load");
        do_req(0, 1, 0, 10, 0, 0, 0, "ovf_add");
        checks++;
        if (bus0.acc !== 7'd2 || bus0.carry !== 1'b1 || bus1.acc !== 7'd127 || bus1.carry !== 1'b1) begin
            errors++;
            $display("FAIL overflow_const: wrap=%0d/%b sat=%0d/%b want 2/1 127/1", bus0.acc, bus0.carry, bus1.acc, bus1.carry);
        end
    endtask

    task automatic test_borrow();
        pulse_clr();
        do_req(1, 0, 3, 0, 0, 0, 0, "brw_load");
        do_req(1, 0, 5, 0, 1, 0, 0, "brw_sub");
        checks++;
        if (bus0.acc !== 7'd126 || bus0.carry !== 1'b1 || bus1.acc !== 7'd0 || bus1.carry !== 1'b1) begin
            errors++;
            $display("FAIL borrow_const: wrap=%0d/%b sat=%0d/%b want 126/1 0/1", bus0.acc, bus0.carry, bus1.acc, bus1.carry);
        end
    endtask

    task automatic test_tie();
        test_reset();
        do_req(1, 1, 3, 4, 0, 0, 0, "tie");
        checks++;
        if (bus0.acc !== 7'd7 || bus1.acc !== 7'd7 || bus0.last_grant !== 1'b1) begin
            errors++;
            $display("FAIL tie_const: acc=%0d/%0d last_grant=%b want 7/7 1", bus0.acc, bus1.acc, bus0.last_grant);
        end
    endtask

    task automatic test_clr_exec();
        pulse_clr();
        do_req(1, 0, 120, 0, 0, 0, 0, "clr_setup1");
        do_req(0, 1, 0, 10, 0, 0, 0, "clr_setup2");
        do_req(1, 0, 48, 0, 0, 0, 0, "clr_setup3");
        checks++;
        if (bus0.acc !== 7'd50 || bus0.carry !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup_const: acc=%0d carry=%b want 50 1", bus0.acc, bus0.carry);
        end
        do_req(1, 0, 9, 0, 0, 0, 1, "clr_exec");
        checks++;
        if (bus0.acc !== 7'd0 || bus0.carry !== 1'b0 || bus1.acc !== 7'd0 || bus1.carry !== 1'b0) begin
            errors++;
            $display("FAIL clr_exec_const: acc=%0d/%0d carry=%b%b want 0/0 00", bus0.acc, bus1.acc, bus0.carry, bus1.carry);
        end
    endtask

    task automatic test_reset_mid();
        do_req(0, 1, 0, 77, 0, 0, 0, "rst_setup");
        op_a = 7'd6; sub_a = 1'b0; req_a = 1'b1;
        step();
        checks++;
        if (bus0.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_load_busy: got %b want 1", bus0.busy);
        end
        #2 resetn = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus0.acc !== '0 || bus1.acc !== '0 || bus0.carry !== 1'b0 || bus0.busy !== 1'b0
            || bus1.busy !== 1'b0 || bus0.last_grant !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_async: acc=%0d/%0d carry=%b busy=%b%b last_grant=%b want 0/0 0 00 1",
                     bus0.acc, bus1.acc, bus0.carry, bus0.busy, bus1.busy, bus0.last_grant);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus0.ack_a, bus0.ack_b, bus1.ack_a, bus1.ack_b} !== 4'b0) begin
                errors++;
                $display("FAIL rst_mid_no_ack: acks=%b want 0000", {bus0.ack_a, bus0.ack_b, bus1.ack_a, bus1.ack_b});
            end
        end
        resetn = 1'b1;
        wait_ack(1'b0, 6, 1'b0, 1'b0, "rst_mid_retry");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            int pat;
            pat = $urandom_range(1, 3);
            if ($urandom_range(0, 7) == 0) pulse_clr();
            do_req(pat[0], pat[1], $urandom_range(0, MAXV), $urandom_range(0, MAXV),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_borrow();
        test_tie();
        test_clr_exec();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
